// File: rtl/stepgen_pkg.sv
// Shared types and default widths for the step/dir generator.
// FSM state encoding and parameter defaults live here.
package stepgen_pkg;

  localparam int STEPS_W_DEF  = 32;
  localparam int PERIOD_W_DEF = 24;
  localparam int TIME_W_DEF   = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    PULSE,
    GAP
  } state_e;

endpackage

// File: rtl/interval_timer.sv
// Loadable down-counter timing every SETUP/PULSE/GAP phase.
// zero_o flags the last cycle of a phase loaded with length-1.
module interval_timer #(
  parameter int W = 24
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  // load wins over count; count saturates at zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/step_dir_gen.sv
// Command-driven step/dir pulse generator.
// Guarantees pulse width, dir setup and edge spacing per move.
module step_dir_gen
  import stepgen_pkg::*;
#(
  parameter int STEPS_W  = STEPS_W_DEF,
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int TIME_W   = TIME_W_DEF
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_dir,
  input  logic [STEPS_W-1:0]  cmd_steps,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic [TIME_W-1:0]   pulse_len,
  input  logic [TIME_W-1:0]   dir_setup,
  input  logic                step_active_high,
  input  logic                abort,
  output logic                step,
  output logic                dir,
  output logic                busy,
  output logic                done,
  output logic [STEPS_W-1:0]  steps_left
);

  localparam int CW =
    ((PERIOD_W > TIME_W) ? PERIOD_W : TIME_W) + 1;

  state_e              state_q, state_d;
  logic                act_q, act_d;
  logic                dir_q, dir_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                abrt_q, abrt_d;
  logic                pol_q, pol_d;
  logic                started_q;
  logic [STEPS_W-1:0]  left_q, left_d;
  logic [TIME_W-1:0]   pw_q, pw_d;
  logic [PERIOD_W-1:0] gap_q, gap_d;

  logic                tld;
  logic [PERIOD_W-1:0] tval;
  logic                tmr_en;
  logic                tz;

  logic [TIME_W-1:0]   pw_in;
  logic [TIME_W-1:0]   su_in;
  logic [CW-1:0]       per_min;
  logic [CW-1:0]       per_in;
  logic [CW-1:0]       per_eff;
  logic [PERIOD_W-1:0] gap_in;
  logic [PERIOD_W-1:0] pw_ld;
  logic                pol_eff;
  logic                stop_pulse;

  // clamp command timing so width >= 1 and gap >= 1
  always_comb begin
    pw_in   = (pulse_len == '0) ? TIME_W'(1) : pulse_len;
    su_in   = (dir_setup == '0) ? TIME_W'(1) : dir_setup;
    per_min = CW'(pw_in) + CW'(1);
    per_in  = CW'(cmd_period);
    per_eff = (per_in < per_min) ? per_min : per_in;
    gap_in  = PERIOD_W'(per_eff - CW'(pw_in));
    pw_ld   = PERIOD_W'(pw_q) - PERIOD_W'(1);
  end

  assign cmd_ready  = started_q && (state_q == IDLE) && !abort;
  assign tmr_en     = (state_q != IDLE);
  assign stop_pulse = abort || abrt_q;

  interval_timer #(
    .W (PERIOD_W)
  ) u_tmr (
    .clk_i  (clk),
    .rst_ni (resetn),
    .load_i (tld),
    .val_i  (tval),
    .en_i   (tmr_en),
    .zero_o (tz)
  );

  // next-state, output and timer-load decisions
  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    dir_d   = dir_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    abrt_d  = abrt_q;
    pol_d   = pol_q;
    left_d  = left_q;
    pw_d    = pw_q;
    gap_d   = gap_q;
    tld     = 1'b0;
    tval    = '0;
    unique case (state_q)
      IDLE: begin
        pol_d  = step_active_high;
        abrt_d = 1'b0;
        if (cmd_valid && cmd_ready) begin
          pw_d   = pw_in;
          gap_d  = gap_in;
          left_d = cmd_steps;
          if (cmd_steps == '0) begin
            done_d = 1'b1;
          end else if (cmd_dir != dir_q) begin
            busy_d  = 1'b1;
            dir_d   = cmd_dir;
            state_d = SETUP;
            tld     = 1'b1;
            tval    = PERIOD_W'(su_in) - PERIOD_W'(1);
          end else begin
            busy_d  = 1'b1;
            act_d   = 1'b1;
            left_d  = cmd_steps - STEPS_W'(1);
            state_d = PULSE;
            tld     = 1'b1;
            tval    = PERIOD_W'(pw_in) - PERIOD_W'(1);
          end
        end
      end
      SETUP: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (tz) begin
          state_d = PULSE;
          act_d   = 1'b1;
          left_d  = left_q - STEPS_W'(1);
          tld     = 1'b1;
          tval    = pw_ld;
        end
      end
      PULSE: begin
        if (abort) begin
          abrt_d = 1'b1;
        end
        if (tz) begin
          act_d = 1'b0;
          if (stop_pulse) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = GAP;
            tld     = 1'b1;
            tval    = gap_q - PERIOD_W'(1);
          end
        end
      end
      GAP: begin
        if (abort || (tz && (left_q == '0))) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (tz) begin
          state_d = PULSE;
          act_d   = 1'b1;
          left_d  = left_q - STEPS_W'(1);
          tld     = 1'b1;
          tval    = pw_ld;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      act_q     <= 1'b0;
      dir_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      abrt_q    <= 1'b0;
      pol_q     <= 1'b1;
      started_q <= 1'b0;
      left_q    <= '0;
      pw_q      <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      act_q     <= act_d;
      dir_q     <= dir_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      abrt_q    <= abrt_d;
      pol_q     <= pol_d;
      started_q <= 1'b1;
      left_q    <= left_d;
      pw_q      <= pw_d;
      gap_q     <= gap_d;
    end
  end

  // until the first edge after reset, idle level follows the pin
  assign pol_eff    = started_q ? pol_q : step_active_high;
  assign step       = act_q ? pol_eff : ~pol_eff;
  assign dir        = dir_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign steps_left = left_q;

endmodule

// File: tb/tb_step_dir_gen.sv
// Scoreboard bench for step_dir_gen.
// Per-cycle expectations are queued from command timing.
module tb_step_dir_gen;

  typedef struct packed {
    logic        step;
    logic        dir;
    logic        busy;
    logic        done;
    logic [31:0] left;
  } exp_t;

  logic        clk;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_dir;
  logic [31:0] cmd_steps;
  logic [23:0] cmd_period;
  logic [15:0] pulse_len;
  logic [15:0] dir_setup;
  logic        step_active_high;
  logic        abort;
  logic        step;
  logic        dir;
  logic        busy;
  logic        done;
  logic [31:0] steps_left;

  int   nvec;
  int   nerr;
  logic pol_b;
  exp_t q[$];

  step_dir_gen dut (
    .clk              (clk),
    .resetn           (resetn),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_dir          (cmd_dir),
    .cmd_steps        (cmd_steps),
    .cmd_period       (cmd_period),
    .pulse_len        (pulse_len),
    .dir_setup        (dir_setup),
    .step_active_high (step_active_high),
    .abort            (abort),
    .step             (step),
    .dir              (dir),
    .busy             (busy),
    .done             (done),
    .steps_left       (steps_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_cyc(input int cnt, input bit a,
                          input bit b, input bit dn,
                          input logic d, input int l);
    exp_t e;
    for (int i = 0; i < cnt; i++) begin
      e.step = a ? pol_b : ~pol_b;
      e.dir  = d;
      e.busy = b;
      e.done = dn;
      e.left = 32'(l);
      q.push_back(e);
    end
  endtask

  task automatic push_move(input bit dchg, input int su,
                           input int pw, input int per,
                           input int n, input logic d);
    int pwe, p, sc;
    pwe = (pw < 1) ? 1 : pw;
    p   = (per < pwe + 1) ? pwe + 1 : per;
    sc  = (su < 1) ? 1 : su;
    if (dchg) push_cyc(sc, 0, 1, 0, d, n);
    for (int k = 0; k < n; k++) begin
      push_cyc(pwe, 1, 1, 0, d, n - 1 - k);
      push_cyc(p - pwe, 0, 1, 0, d, n - 1 - k);
    end
    push_cyc(1, 0, 0, 1, d, 0);
  endtask

  task automatic issue(input logic d, input int n,
                       input int per, input int pl,
                       input int ds, input bit hold);
    @(negedge clk);
    nvec++;
    if (cmd_ready !== 1'b1) begin
      nerr++;
      $display("FAIL issue_ready: got %b want 1", cmd_ready);
    end
    cmd_dir    = d;
    cmd_steps  = 32'(n);
    cmd_period = 24'(per);
    pulse_len  = 16'(pl);
    dir_setup  = 16'(ds);
    cmd_valid  = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic drain(input string nm, input int abort_at,
                       input int drop_at);
    exp_t e, o;
    int   i;
    i = 0;
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      o = {step, dir, busy, done, steps_left};
      nvec++;
      if (o !== e) begin
        nerr++;
        $display({"FAIL %s cyc%0d: got step=%b dir=%b busy=%b",
                  " done=%b left=%0d want step=%b dir=%b",
                  " busy=%b done=%b left=%0d"},
                 nm, i, o.step, o.dir, o.busy, o.done, o.left,
                 e.step, e.dir, e.busy, e.done, e.left);
      end
      abort = (i == abort_at);
      if (i == drop_at) cmd_valid = 1'b0;
      i++;
    end
    abort = 1'b0;
  endtask

  task automatic chk1(input string nm, input logic got,
                      input logic want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %b want %b", nm, got, want);
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    #2;
    chk1("rst_step", step, 1'b0);
    chk1("rst_dir", dir, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_ready", cmd_ready, 1'b0);
    nvec++;
    if (steps_left !== 32'd0) begin
      nerr++;
      $display("FAIL rst_left: got %0d want 0", steps_left);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    #1;
    chk1("rel_ready0", cmd_ready, 1'b0);
    @(negedge clk);
    chk1("rel_ready1", cmd_ready, 1'b1);
  endtask

  task automatic test_basic;
    issue(0, 3, 5, 2, 0, 0);
    push_move(0, 0, 2, 5, 3, 0);
    drain("basic", -1, -1);
    @(negedge clk);
    chk1("basic_done_clr", done, 1'b0);
    chk1("basic_idle_step", step, 1'b0);
  endtask

  task automatic test_dir_change;
    issue(1, 1, 5, 2, 4, 0);
    push_move(1, 4, 2, 5, 1, 1);
    drain("dirchg", -1, -1);
  endtask

  task automatic test_clamp;
    issue(1, 3, 1, 3, 0, 0);
    push_move(0, 0, 3, 1, 3, 1);
    drain("clamp", -1, -1);
  endtask

  task automatic test_abort_pulse;
    issue(1, 10, 6, 3, 0, 0);
    for (int k = 0; k < 3; k++) begin
      push_cyc(3, 1, 1, 0, 1, 9 - k);
      push_cyc(3, 0, 1, 0, 1, 9 - k);
    end
    push_cyc(3, 1, 1, 0, 1, 6);
    push_cyc(1, 0, 0, 1, 1, 6);
    drain("abort_pulse", 19, -1);
    chk1("abort_pulse_ready", cmd_ready, 1'b1);
  endtask

  task automatic test_zero;
    issue(0, 0, 5, 2, 0, 0);
    push_cyc(1, 0, 0, 1, 1, 0);
    drain("zero", -1, -1);
    chk1("zero_ready", cmd_ready, 1'b1);
    @(negedge clk);
    chk1("zero_busy", busy, 1'b0);
    chk1("zero_done_clr", done, 1'b0);
  endtask

  task automatic test_abort_gap;
    issue(1, 5, 5, 2, 0, 0);
    push_cyc(2, 1, 1, 0, 1, 4);
    push_cyc(2, 0, 1, 0, 1, 4);
    push_cyc(1, 0, 0, 1, 1, 4);
    drain("abort_gap", 3, -1);
  endtask

  task automatic test_abort_setup;
    issue(0, 3, 5, 2, 4, 0);
    push_cyc(2, 0, 1, 0, 0, 3);
    push_cyc(1, 0, 0, 1, 0, 3);
    drain("abort_setup", 1, -1);
  endtask

  task automatic test_back_to_back;
    issue(0, 2, 5, 2, 0, 1);
    cmd_steps  = 32'd1;
    cmd_period = 24'd3;
    pulse_len  = 16'd1;
    push_move(0, 0, 2, 5, 2, 0);
    push_move(0, 0, 1, 3, 1, 0);
    drain("b2b", -1, 11);
  endtask

  task automatic test_polarity;
    @(negedge clk);
    step_active_high = 1'b0;
    #1;
    chk1("pol_hold", step, 1'b0);
    @(negedge clk);
    chk1("pol_idle_low", step, 1'b1);
    pol_b = 1'b0;
    issue(0, 1, 3, 2, 0, 0);
    push_move(0, 0, 2, 3, 1, 0);
    drain("pol_low", -1, -1);
    step_active_high = 1'b1;
    pol_b = 1'b1;
    #1;
    chk1("pol_back_hold", step, 1'b1);
    @(negedge clk);
    chk1("pol_back", step, 1'b0);
  endtask

  task automatic test_reset_mid;
    issue(1, 5, 5, 2, 1, 0);
    repeat (4) @(negedge clk);
    chk1("mid_in_gap", busy, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    chk1("mid_step", step, 1'b0);
    chk1("mid_dir", dir, 1'b0);
    chk1("mid_busy", busy, 1'b0);
    chk1("mid_done", done, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    issue(0, 2, 4, 1, 0, 0);
    push_move(0, 0, 1, 4, 2, 0);
    drain("post_rst", -1, -1);
  endtask

  initial begin
    nvec             = 0;
    nerr             = 0;
    pol_b            = 1'b1;
    resetn           = 1'b0;
    cmd_valid        = 1'b0;
    cmd_dir          = 1'b0;
    cmd_steps        = '0;
    cmd_period       = '0;
    pulse_len        = '0;
    dir_setup        = '0;
    step_active_high = 1'b1;
    abort            = 1'b0;
    test_reset();
    test_basic();
    test_dir_change();
    test_clamp();
    test_abort_pulse();
    test_zero();
    test_abort_gap();
    test_abort_setup();
    test_back_to_back();
    test_polarity();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
